// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
// mem_port_arbiter: shares one req/ack memory between the fetch and
// data ports, with flush drop, anti-starvation and watchdog abort.
// Ports: clk/reset (sync, active-low); if_* fetch port; d_* data port;
// flush cancels fetch; mem_* memory handshake; err sticky timeout.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  output logic          if_busy,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          d_busy,
  input  logic          flush,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  localparam int BW = DW / 8;
  localparam int RW = $clog2(MAX_DATA_RUN + 1);
  localparam int WW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [WW-1:0] WD_LAST =
    WD_EN ? WW'(TIMEOUT - 1) : '0;
  localparam logic [RW-1:0] RUN_MAX =
    RW'(MAX_DATA_RUN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DATA,
    S_DROP
  } state_e;

  state_e          state_q;
  logic [RW-1:0]   run_q;
  logic [WW-1:0]   wd_q;
  logic [AW-1:0]   addr_q;
  logic            we_q;
  logic [DW-1:0]   wdata_q;
  logic [BW-1:0]   be_q;
  logic [DW-1:0]   if_rdata_q;
  logic [DW-1:0]   d_rdata_q;
  logic            if_valid_q;
  logic            d_valid_q;
  logic            err_q;

  logic if_pend;
  logic d_pend;
  logic grant_d;
  logic grant_f;
  logic wd_hit;

  // A port completing this cycle must not be re-granted on its
  // stale request; flush kills the fetch request outright.
  assign if_pend = if_req & ~if_valid_q & ~flush;
  assign d_pend  = d_req & ~d_valid_q;

  assign grant_d = d_pend &
    ~(if_pend & (run_q == RUN_MAX));
  assign grant_f = if_pend & ~grant_d;

  // Last permitted cycle of a granted access.
  assign wd_hit = WD_EN && (wd_q == WD_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      run_q      <= '0;
      wd_q       <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      wd_q       <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (grant_d) begin
            state_q <= S_DATA;
            addr_q  <= d_addr;
            we_q    <= d_we;
            wdata_q <= d_wdata;
            be_q    <= d_be;
            run_q   <= if_pend ? run_q + RW'(1) : '0;
          end else if (grant_f) begin
            state_q <= S_FETCH;
            addr_q  <= if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '1;
            run_q   <= '0;
          end
        end
        S_FETCH: begin
          if (mem_ack) begin
            state_q <= S_IDLE;
            if (!flush) begin
              if_rdata_q <= mem_rdata;
              if_valid_q <= 1'b1;
            end
          end else if (wd_hit) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
            if (!flush) begin
              if_rdata_q <= '0;
              if_valid_q <= 1'b1;
            end
          end else if (flush) begin
            state_q <= S_DROP;
            wd_q    <= wd_q + WW'(1);
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        S_DATA: begin
          if (mem_ack) begin
            state_q   <= S_IDLE;
            d_valid_q <= 1'b1;
            if (!we_q) d_rdata_q <= mem_rdata;
          end else if (wd_hit) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b1;
            d_valid_q <= 1'b1;
            d_rdata_q <= '0;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
        S_DROP: begin
          if (mem_ack) begin
            state_q <= S_IDLE;
          end else if (wd_hit) begin
            state_q <= S_IDLE;
            err_q   <= 1'b1;
          end else begin
            wd_q <= wd_q + WW'(1);
          end
        end
      endcase
    end
  end

  assign mem_req   = (state_q != S_IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  assign if_rdata = if_rdata_q;
  assign if_valid = if_valid_q;
  assign d_rdata  = d_rdata_q;
  assign d_valid  = d_valid_q;
  assign err      = err_q;

  assign if_busy = if_req & ~if_valid_q;
  assign d_busy  = d_req & ~d_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
// tb_mem_port_arbiter: directed vectors and scripted sequences
// against a small variable-latency memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        if_busy;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_busy;
  logic        flush;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .AW(32), .DW(32),
    .MAX_DATA_RUN(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .if_busy(if_busy),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_valid(d_valid),
    .d_busy(d_busy), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .err(err)
  );

  // Memory model: acks ack_dly cycles into mem_req.
  int ack_dly = 0;
  bit ack_en  = 1'b1;
  int acnt    = 0;
  always @(posedge clk)
    if (!mem_req || mem_ack) acnt <= 0;
    else acnt <= acnt + 1;
  assign mem_ack = mem_req && ack_en &&
                   (acnt == ack_dly);
  assign mem_rdata = (mem_addr == 32'h40) ?
    32'h0050_0093 : (mem_addr ^ 32'hC0DE_0000);

  // Optional flush in every load-completion cycle.
  logic flush_drv;
  logic fl_on_dv;
  assign flush = flush_drv | (fl_on_dv & d_valid);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic        mreq;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic        iv;
    logic        dv;
    logic [31:0] ird;
    logic [31:0] drd;
    logic        ib;
    logic        db;
    logic        er;
  } snap_t;

  snap_t tr [64];
  snap_t last;
  bit auto_d = 1'b1;
  bit auto_i = 1'b1;

  task automatic sample(input int c);
    @(negedge clk);
    tr[c] = '{mreq: mem_req, mwe: mem_we,
              maddr: mem_addr, mwd: mem_wdata,
              iv: if_valid, dv: d_valid,
              ird: if_rdata, drd: d_rdata,
              ib: if_busy, db: d_busy, er: err};
    last = tr[c];
  endtask

  // Requesters drop req the cycle after their valid.
  task automatic step();
    @(posedge clk);
    #1;
    if (last.dv && auto_d) d_req = 1'b0;
    if (last.iv && auto_i) if_req = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    if_req = 1'b0;
    d_req = 1'b0;
    flush_drv = 1'b0;
    fl_on_dv = 1'b0;
    ack_en = 1'b1;
    ack_dly = 0;
    auto_d = 1'b1;
    auto_i = 1'b1;
    last = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    bit          isd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          dly;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs [7];

  task automatic single(input vec_t v,
                        output int lat,
                        output logic [31:0] rd,
                        output logic [31:0] ga,
                        output logic [31:0] gwd,
                        output logic gwe,
                        output logic [3:0] gbe,
                        output logic b01,
                        output logic bv);
    bit seen;
    seen = 1'b0;
    lat = -1;
    rd = '0; ga = '0; gwd = '0;
    gwe = 1'b0; gbe = '0;
    b01 = 1'b1; bv = 1'b1;
    ack_dly = v.dly;
    if (v.isd) begin
      d_we = v.we; d_addr = v.addr;
      d_wdata = v.wdata; d_be = v.be;
      d_req = 1'b1;
    end else begin
      if_addr = v.addr;
      if_req = 1'b1;
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c < 2)
        b01 = b01 & (v.isd ? d_busy : if_busy);
      if (mem_req && !seen) begin
        seen = 1'b1;
        ga = mem_addr; gwd = mem_wdata;
        gwe = mem_we; gbe = mem_be;
      end
      if (v.isd ? d_valid : if_valid) begin
        lat = c;
        rd = v.isd ? d_rdata : if_rdata;
        bv = v.isd ? d_busy : if_busy;
      end
      @(posedge clk);
      #1;
      if (lat >= 0) break;
    end
    d_req = 1'b0;
    if_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: sim did not end");
    $fatal(1);
  end

  initial begin
    int lat;
    logic [31:0] rd, ga, gwd;
    logic gwe, b01, bv;
    logic [3:0] gbe;
    string got;
    int ndv;
    int nif;

    reset = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_be = '0;
    flush_drv = 1'b0; fl_on_dv = 1'b0;
    last = '0;

    vecs[0] = '{0, 0, 32'h40, 0, 4'hF, 0,
                32'h0050_0093, 2};
    vecs[1] = '{0, 0, 32'h44, 0, 4'hF, 2,
                32'hC0DE_0044, 4};
    vecs[2] = '{1, 0, 32'h200, 0, 4'hF, 1,
                32'hC0DE_0200, 3};
    vecs[3] = '{1, 1, 32'h300, 32'h1234_5678,
                4'h3, 0, 32'hC0DE_0200, 2};
    vecs[4] = '{1, 0, 32'h7FC, 0, 4'hF, 5,
                32'hC0DE_07FC, 7};
    vecs[5] = '{1, 0, 32'h10, 0, 4'hF, 7,
                32'hC0DE_0010, 9};
    vecs[6] = '{0, 0, 32'h48, 0, 4'hF, 7,
                32'hC0DE_0048, 9};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 7; i++) begin
      single(vecs[i], lat, rd, ga, gwd,
             gwe, gbe, b01, bv);
      chk($sformatf("v%0d_lat", i), lat,
          vecs[i].exp_lat);
      chk($sformatf("v%0d_rdata", i), rd,
          vecs[i].exp_rd);
      chk($sformatf("v%0d_addr", i), ga,
          vecs[i].addr);
      chk($sformatf("v%0d_we", i), gwe,
          vecs[i].isd ? vecs[i].we : 1'b0);
      chk($sformatf("v%0d_be", i), gbe,
          vecs[i].isd ? vecs[i].be : 4'hF);
      chk($sformatf("v%0d_wdata", i), gwd,
          vecs[i].isd ? vecs[i].wdata : 32'h0);
      chk($sformatf("v%0d_busy01", i), b01, 1);
      chk($sformatf("v%0d_busyv", i), bv, 0);
    end

    // Simultaneous store and fetch: data first.
    do_reset();
    d_we = 1'b1; d_addr = 32'h100;
    d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    d_req = 1'b1;
    if_addr = 32'h80; if_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      sample(c);
      step();
    end
    chk("t2_c1_req", tr[1].mreq, 1);
    chk("t2_c1_we", tr[1].mwe, 1);
    chk("t2_c1_addr", tr[1].maddr, 32'h100);
    chk("t2_c1_wdata", tr[1].mwd, 32'hDEAD_BEEF);
    chk("t2_c2_dvalid", tr[2].dv, 1);
    chk("t2_c2_ifbusy", tr[2].ib, 1);
    chk("t2_c2_dbusy", tr[2].db, 0);
    chk("t2_c3_addr", tr[3].maddr, 32'h80);
    chk("t2_c3_we", tr[3].mwe, 0);
    chk("t2_c4_ifvalid", tr[4].iv, 1);
    chk("t2_c4_ifrdata", tr[4].ird, 32'hC0DE_0080);

    // Six loads against a held fetch. Flushing in each
    // load's valid cycle keeps the fetch masked in the only
    // idle cycle, so the run limit decides the fetch slot.
    do_reset();
    auto_d = 1'b0; auto_i = 1'b0;
    fl_on_dv = 1'b1;
    d_we = 1'b0; d_addr = 32'h400; d_be = 4'hF;
    d_wdata = '0;
    d_req = 1'b1;
    if_addr = 32'h80; if_req = 1'b1;
    got = "";
    ndv = 0;
    for (int c = 0; c < 26; c++) begin
      sample(c);
      if (c > 0 && tr[c].mreq && !tr[c-1].mreq &&
          got.len() < 7) begin
        if (tr[c].maddr == 32'h80) got = {got, "F"};
        else got = {got, "D"};
      end
      if (tr[c].dv) ndv++;
      step();
      if (ndv == 6) d_req = 1'b0;
    end
    checks++;
    if (got != "DDDDFDD") begin
      errors++;
      $display("FAIL t3_order: got %s expected %s",
               got, "DDDDFDD");
    end
    chk("t3_loads", ndv, 6);

    // Flush during fetch: drop, then a fresh fetch.
    do_reset();
    ack_dly = 3;
    nif = 0;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin if_addr = 32'h60; if_req = 1'b1; end
        1: flush_drv = 1'b1;
        2: begin flush_drv = 1'b0; if_addr = 32'h80; end
        5: ack_dly = 0;
        default: ;
      endcase
      sample(c);
      if (c < 7 && tr[c].iv) nif++;
      step();
    end
    chk("t4_c2_req", tr[2].mreq, 1);
    chk("t4_c3_req", tr[3].mreq, 1);
    chk("t4_c4_req", tr[4].mreq, 1);
    chk("t4_c4_addr", tr[4].maddr, 32'h60);
    chk("t4_c2_we", tr[2].mwe, 0);
    chk("t4_c5_req", tr[5].mreq, 0);
    chk("t4_c5_busy", tr[5].ib, 1);
    chk("t4_no_valid", nif, 0);
    chk("t4_c6_addr", tr[6].maddr, 32'h80);
    chk("t4_c7_valid", tr[7].iv, 1);
    chk("t4_c7_rdata", tr[7].ird, 32'hC0DE_0080);

    // Watchdog on a never-acked load.
    do_reset();
    for (int c = 0; c < 18; c++) begin
      case (c)
        0: begin
          d_we = 1'b0; d_addr = 32'h204;
          d_be = 4'hF; d_req = 1'b1;
        end
        3: begin
          ack_en = 1'b0;
          d_addr = 32'h500; d_req = 1'b1;
        end
        13: ack_en = 1'b1;
        14: begin if_addr = 32'h44; if_req = 1'b1; end
        default: ;
      endcase
      sample(c);
      step();
    end
    chk("t5_c2_rdata", tr[2].drd, 32'hC0DE_0204);
    chk("t5_c11_req", tr[11].mreq, 1);
    chk("t5_c11_err", tr[11].er, 0);
    chk("t5_c12_req", tr[12].mreq, 0);
    chk("t5_c12_dvalid", tr[12].dv, 1);
    chk("t5_c12_rdata", tr[12].drd, 0);
    chk("t5_c12_err", tr[12].er, 1);
    chk("t5_c16_ifvalid", tr[16].iv, 1);
    chk("t5_c16_ifrdata", tr[16].ird, 32'hC0DE_0044);
    chk("t5_c16_err", tr[16].er, 1);
    do_reset();
    @(negedge clk);
    chk("t5_rst_err", err, 0);

    // Reset while a load waits for ack.
    do_reset();
    ndv = 0;
    for (int c = 0; c < 10; c++) begin
      case (c)
        0: begin
          d_we = 1'b0; d_addr = 32'h208;
          d_be = 4'hF; d_req = 1'b1;
        end
        3: begin
          ack_dly = 5;
          d_addr = 32'h20C; d_req = 1'b1;
        end
        5: reset = 1'b0;
        6: begin reset = 1'b1; d_req = 1'b0; end
        default: ;
      endcase
      sample(c);
      if (c >= 6 && tr[c].dv) ndv++;
      step();
    end
    chk("t6_c5_req", tr[5].mreq, 1);
    chk("t6_c5_rdata", tr[5].drd, 32'hC0DE_0208);
    chk("t6_c6_req", tr[6].mreq, 0);
    chk("t6_c6_rdata", tr[6].drd, 0);
    chk("t6_c6_err", tr[6].er, 0);
    chk("t6_no_valid", ndv, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch (IF) port and its data (MEM-stage load/store) port.
- Grants one access at a time under a req/ack memory handshake.
- Returns per-port busy/valid signals; the hazard logic ORs busy into stallF/stallD.
- Honours branch flushes by discarding in-flight fetch results. Includes anti-starvation and a watchdog timeout.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_DATA_RUN, 4, max consecutive data grants while a fetch is pending before fetch is forced (≥1)
TIMEOUT, 255, cycles in a granted state before watchdog abort; 0 disables

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
if_req  in  1  fetch request; held until if_valid
if_addr  in  AW  fetch address; stable while if_req
if_rdata  out  DW  fetch data, registered
if_valid  out  1  one-cycle completion pulse for fetch
if_busy  out  1  if_req & ~if_valid; feeds fetch/decode stall
d_req  in  1  data request; held until d_valid
d_we  in  1  1=store, 0=load
d_addr  in  AW  data address
d_wdata  in  DW  store data
d_be  in  DW/8  byte enables
d_rdata  out  DW  load data, registered
d_valid  out  1  one-cycle completion pulse for data
d_busy  out  1  d_req & ~d_valid
flush  in  1  branch taken (PcSrcE); cancels fetch
mem_req  out  1  memory request
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_be  out  DW/8  memory byte enables
mem_ack  in  1  memory completion, valid only while mem_req=1
mem_rdata  in  DW  read data, valid with mem_ack
err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset: clk-synchronous, when reset=0. State=IDLE; run and watchdog counters=0. Outputs: mem_req=0, if_valid=0, d_valid=0, if_rdata=0, d_rdata=0, err=0. Reset mid-access abandons the access; no valid is pulsed.
- States: IDLE, FETCH, DATA, DROP.
  - mem_req=1 in FETCH, DATA and DROP.
  - mem_addr/we/wdata/be are latched at grant and held stable until ack.
  - mem_we=0 in FETCH and DROP.
- Masking: a port whose valid is high in the current cycle is treated as not requesting. flush masks if_req in the same cycle.
- IDLE arbitration:
  - Data wins if d_req is unmasked, unless the fetch is unmasked and run_cnt==MAX_DATA_RUN; then fetch wins.
  - On a data grant, run_cnt increments if a fetch is pending, otherwise clears.
  - On a fetch grant, run_cnt clears.
- FETCH:
  - mem_ack & ~flush: if_rdata<=mem_rdata, if_valid=1 next cycle, go to IDLE.
  - mem_ack & flush: discard data, no valid, go to IDLE.
  - flush without ack: go to DROP.
- DROP: wait for mem_ack, discard data, go to IDLE, no if_valid.
- DATA: on mem_ack, d_rdata<=mem_rdata for loads (unchanged for stores), d_valid=1 next cycle, go to IDLE. flush has no effect in DATA.
- Latency: request seen in IDLE at cycle 0 → mem_req from cycle 1 → ack at cycle N≥1 → valid at N+1. Minimum is 2 cycles. The next grant can occur in the valid cycle at the earliest (other port) or the following cycle (same port).
- Watchdog:
  - wd_cnt counts cycles in FETCH/DATA/DROP and clears in IDLE.
  - When wd_cnt reaches TIMEOUT: set err, go to IDLE, drop mem_req. The owning port's valid pulses with rdata=0; DROP pulses nothing.
  - err clears only on reset.
- if_busy/d_busy are combinational and have no cycle delay.

Test Plan:
1. if_req=1, addr=0x40; memory acks 1 cycle after mem_req with 0x00500093 → if_valid pulses at cycle 2 with if_rdata=0x00500093; if_busy is high in cycles 0–1.
2. if_req and d_req both rise at cycle 0; d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF, d_be=0xF → data is granted first with mem_we=1 and d_valid; then fetch is granted and completes with if_valid.
3. if_req held continuously while d_req issues 6 back-to-back loads, MAX_DATA_RUN=4 → grant order D,D,D,D,F,D,D.
4. Fetch granted, flush pulses 1 cycle while memory acks 3 cycles later → state goes to DROP, mem_req stays high until ack, no if_valid. A new fetch to 0x80 issued after flush then completes normally.
5. TIMEOUT=8, data load is never acked → after 8 cycles mem_req=0, d_valid pulses with d_rdata=0, err=1 and stays 1 through later traffic until reset=0.
6. reset=0 asserted while in DATA awaiting ack → next cycle state=IDLE, mem_req=0, no valid pulses, err=0.
